// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU datapath and the flash loader.
// Load mode hands the RAM to the loader; run mode favours flash with a bounded CPU wait.
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int RAM_ADDR_W = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flash_en,
    input  logic                  flash_req,
    input  logic [WIDTH-1:0]      flash_addr,
    input  logic [WIDTH-1:0]      flash_wdata,
    output logic                  flash_gnt,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [WIDTH-1:0]      cpu_addr,
    input  logic [WIDTH-1:0]      cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [WIDTH-1:0]      cpu_rdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  ram_wren,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_wdata,
    input  logic [WIDTH-1:0]      ram_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {RUN, LOAD, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;

    // Grants are masked while reset is held so nothing reaches the RAM.
    always_comb begin
        flash_gnt = 1'b0;
        cpu_gnt   = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    flash_gnt = flash_req & ~(cpu_req & (wait_cnt_q == WAIT_MAX));
                    cpu_gnt   = cpu_req & ~flash_gnt;
                end
                LOAD:    flash_gnt = flash_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flash_en) state_d = LOAD;
            LOAD:    if (!flash_en) state_d = RELEASE;
            default: state_d = RUN;
        endcase

        wait_cnt_d = '0;
        if (state_q == RUN && cpu_req && !cpu_gnt)
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + CW'(1);

        cpu_rvalid_d = cpu_gnt & ~cpu_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    // Word addressing: byte offset dropped, upper bits ignored so addresses wrap.
    always_comb begin
        ram_wren  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (flash_gnt) begin
            ram_wren  = 1'b1;
            ram_addr  = flash_addr[RAM_ADDR_W+1:2];
            ram_wdata = flash_wdata;
        end else if (cpu_gnt) begin
            ram_wren  = cpu_we;
            ram_addr  = cpu_addr[RAM_ADDR_W+1:2];
            ram_wdata = cpu_wdata;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? ram_rdata : '0;
    assign cpu_hold   = (state_q != RUN);
    assign load_done  = (state_q == RELEASE);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{flash_addr[WIDTH-1:RAM_ADDR_W+2], flash_addr[1:0],
                                cpu_addr[WIDTH-1:RAM_ADDR_W+2], cpu_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed phases, behavioural RAM, read-data scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flash_en, flash_req, cpu_req, cpu_we;
    logic [31:0] flash_addr, flash_wdata, cpu_addr, cpu_wdata;
    logic        flash_gnt, cpu_gnt, cpu_rvalid, cpu_hold, load_done, ram_wren;
    logic [31:0] cpu_rdata, ram_wdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem    [1024];
    logic [31:0] shadow [1024];
    logic [31:0] sb [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .RAM_ADDR_W(10), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .flash_en(flash_en), .flash_req(flash_req), .flash_addr(flash_addr),
        .flash_wdata(flash_wdata), .flash_gnt(flash_gnt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_hold(cpu_hold), .load_done(load_done),
        .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("rdata", cpu_rdata, sb.pop_front());
        end
    end

    task automatic step(input string tag, input logic efg, input logic ecg, input logic erv,
                        input logic eh, input logic eld, input logic ewr, input logic [9:0] ead);
        @(negedge clk);
        chk({tag, ".flash_gnt"}, 32'(flash_gnt), 32'(efg));
        chk({tag, ".cpu_gnt"},   32'(cpu_gnt),   32'(ecg));
        chk({tag, ".rvalid"},    32'(cpu_rvalid), 32'(erv));
        chk({tag, ".hold"},      32'(cpu_hold),  32'(eh));
        chk({tag, ".load_done"}, 32'(load_done), 32'(eld));
        chk({tag, ".wren"},      32'(ram_wren),  32'(ewr));
        chk({tag, ".addr"},      32'(ram_addr),  32'(ead));
        @(posedge clk); #1;
    endtask

    task automatic idle();
        flash_en = 0; flash_req = 0; cpu_req = 0; cpu_we = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin mem[i] = '0; shadow[i] = '0; end
        // Reset with every request high: all outputs must stay quiet.
        rst = 1; flash_en = 1; flash_req = 1; cpu_req = 1; cpu_we = 1;
        flash_addr = 32'h10; flash_wdata = 32'h1; cpu_addr = 32'h8; cpu_wdata = 32'h2;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.flash_gnt", 32'(flash_gnt), 0);
        chk("rst.cpu_gnt",   32'(cpu_gnt), 0);
        chk("rst.rvalid",    32'(cpu_rvalid), 0);
        chk("rst.rdata",     cpu_rdata, 0);
        chk("rst.hold",      32'(cpu_hold), 0);
        chk("rst.load_done", 32'(load_done), 0);
        chk("rst.wren",      32'(ram_wren), 0);
        chk("rst.addr",      32'(ram_addr), 0);
        chk("rst.wdata",     ram_wdata, 0);
        @(posedge clk); #1;
        rst = 0; flash_en = 0; cpu_we = 0; flash_wdata = 32'h0;
        shadow[4] = 32'h0;
        step("run0", 1, 0, 0, 0, 0, 1, 10'd4);
        idle();
        step("idle0", 0, 0, 0, 0, 0, 0, 10'd0);

        // Load mode
        flash_en = 1; flash_req = 1; flash_addr = 32'h10; flash_wdata = 32'hDEADBEEF;
        shadow[4] = 32'hDEADBEEF;
        step("ld_enter", 1, 0, 0, 0, 0, 1, 10'd4);
        flash_addr = 32'h14; flash_wdata = 32'hCAFEF00D; cpu_req = 1; cpu_addr = 32'h0;
        shadow[5] = 32'hCAFEF00D;
        step("ld_wr", 1, 0, 0, 1, 0, 1, 10'd5);
        flash_req = 0; flash_en = 0;
        step("ld_drop", 0, 0, 0, 1, 0, 0, 10'd0);
        step("release", 0, 0, 0, 1, 1, 0, 10'd0);
        cpu_addr = 32'h10; sb.push_back(shadow[4]);
        step("ld_run", 0, 1, 0, 0, 0, 0, 10'd4);
        idle();
        step("ld_rv", 0, 0, 1, 0, 0, 0, 10'd0);

        // CPU write then pipelined reads
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'h00001234;
        shadow[2] = 32'h00001234;
        step("rd_wr", 0, 1, 0, 0, 0, 1, 10'd2);
        cpu_we = 0; sb.push_back(shadow[2]);
        step("rd_a", 0, 1, 0, 0, 0, 0, 10'd2);
        cpu_addr = 32'h14; sb.push_back(shadow[5]);
        step("rd_b", 0, 1, 1, 0, 0, 0, 10'd5);
        idle();
        step("rd_c", 0, 0, 1, 0, 0, 0, 10'd0);
        step("rd_d", 0, 0, 0, 0, 0, 0, 10'd0);

        // Contention: flash wins 4, CPU wins the 5th
        flash_req = 1; flash_addr = 32'h20; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        for (int k = 0; k < 10; k++) begin
            logic fg;
            fg = (k % 5 != 4);
            flash_wdata = 32'(k);
            if (fg) shadow[8] = 32'(k);
            else sb.push_back(shadow[4]);
            step($sformatf("cont%0d", k), fg, !fg, (k % 5 == 0) && (k > 0), 0, 0, fg,
                 fg ? 10'd8 : 10'd4);
        end
        idle();
        step("cont_end", 0, 0, 1, 0, 0, 0, 10'd0);

        // Reset while in load, one cycle after a CPU read grant
        flash_en = 1; cpu_req = 1; cpu_addr = 32'h8; sb.push_back(shadow[2]);
        step("mr_t", 0, 1, 0, 0, 0, 0, 10'd2);
        rst = 1;
        @(negedge clk);
        chk("mr_rst.rvalid", 32'(cpu_rvalid), 1);
        chk("mr_rst.cpu_gnt", 32'(cpu_gnt), 0);
        @(posedge clk); #1;
        rst = 0; flash_en = 0; flash_req = 1; flash_wdata = 32'h77; flash_addr = 32'h20;
        shadow[8] = 32'h77;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) sb.push_back(shadow[2]);
            step($sformatf("mr%0d", k), k < 4, k == 4, 0, 0, 0, k < 4,
                 (k < 4) ? 10'd8 : 10'd2);
        end
        idle();
        step("mr_end", 0, 0, 1, 0, 0, 0, 10'd0);

        // Address wrap
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h00001006; cpu_wdata = 32'h55;
        shadow[1] = 32'h55;
        step("wrap_wr", 0, 1, 0, 0, 0, 1, 10'd1);
        cpu_we = 0; cpu_addr = 32'h4; sb.push_back(shadow[1]);
        step("wrap_rd", 0, 1, 0, 0, 0, 0, 10'd1);
        idle();
        step("wrap_rv", 0, 0, 1, 0, 0, 0, 10'd0);
        step("tail", 0, 0, 0, 0, 0, 0, 10'd0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
